// File: rtl/rf_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
// The build option RF_BYPASS_EN lives in reg_file_2r1w.sv and rf_read_port.sv.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   rf_addr_t;
  typedef logic [XLEN_DEF-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered register-file read port with x0 masking.
// Macro RF_BYPASS_EN selects write-first forwarding; undefined gives read-first.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic            busy_i,
`ifdef RF_BYPASS_EN
  input  logic            busyNext_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
`endif
  output logic [XLEN-1:0] data_o,
  output logic            busy_o
);

  logic [XLEN-1:0] data_q, data_d;
  logic            busy_q, busy_d;

  // x0 masking is applied last so a forwarded write to x0 can never leak out.
  always_comb begin
    data_d = rdata_i;
    busy_d = busy_i;
`ifdef RF_BYPASS_EN
    busy_d = busyNext_i;
    if (we_i && (waddr_i == addr_i)) begin
      data_d = wdata_i;
    end
`endif
    if (addr_i == AW'(ZERO_REG)) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// RISC-V GPR file: two registered read ports, one write port, per-register busy scoreboard.
// Define RF_BYPASS_EN for write-first reads on a same-cycle collision; default is read-first.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra_addr,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data,
  output logic            ra_busy,
  output logic            rb_busy,
  input  logic            we,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wd,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  // Set is applied after clear: the write retires an older producer while the new one is still pending.
  always_comb begin
    busy_d = busy_q;
    if (we) begin
      busy_d[wa_addr] = 1'b0;
    end
    if (busy_set) begin
      busy_d[busy_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (we && (wa_addr != AW'(ZERO_REG))) begin
        regs_q[wa_addr] <= wd;
      end
      busy_q <= busy_d;
    end
  end

  rf_read_port #(.XLEN(XLEN), .AW(AW)) u_portA (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (ra_addr),
    .rdata_i    (regs_q[ra_addr]),
    .busy_i     (busy_q[ra_addr]),
`ifdef RF_BYPASS_EN
    .busyNext_i (busy_d[ra_addr]),
    .we_i       (we),
    .waddr_i    (wa_addr),
    .wdata_i    (wd),
`endif
    .data_o     (ra_data),
    .busy_o     (ra_busy)
  );

  rf_read_port #(.XLEN(XLEN), .AW(AW)) u_portB (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (rb_addr),
    .rdata_i    (regs_q[rb_addr]),
    .busy_i     (busy_q[rb_addr]),
`ifdef RF_BYPASS_EN
    .busyNext_i (busy_d[rb_addr]),
    .we_i       (we),
    .waddr_i    (wa_addr),
    .wdata_i    (wd),
`endif
    .data_o     (rb_data),
    .busy_o     (rb_busy)
  );

endmodule
